// File: rtl/raifes_qspi_mem_responder.sv
// QSPI memory responder: device end of a mode-0 QSPI link, oversampled in the iClk domain,
// backed by an internal byte array with a backdoor access port.
module raifes_qspi_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iSCK,
  input  logic                  inCS,
  input  logic                  iIO0_In,
  input  logic                  iIO1_In,
  input  logic                  iIO2_In,
  input  logic                  iIO3_In,
  output logic                  oIO0_Out,
  output logic                  oIO1_Out,
  output logic                  oIO2_Out,
  output logic                  oIO3_Out,
  output logic                  oIO0_En,
  output logic                  oIO1_En,
  output logic                  oIO2_En,
  output logic                  oIO3_En,
  input  logic                  iBd_We,
  input  logic [ADDR_WIDTH-1:0] iBd_Addr,
  input  logic [7:0]            iBd_WData,
  output logic [7:0]            oBd_RData,
  output logic                  oWEL,
  output logic                  oBusy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SW    = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
  localparam int CNT_W = ($clog2(DUMMY_CYCLES + 1) > 5) ? $clog2(DUMMY_CYCLES + 1) : 5;

  localparam logic [7:0] OpRead  = 8'h03;
  localparam logic [7:0] OpQRead = 8'h6B;
  localparam logic [7:0] OpWrite = 8'h02;
  localparam logic [7:0] OpRdsr  = 8'h05;
  localparam logic [7:0] OpWren  = 8'h06;
  localparam logic [7:0] OpWrdi  = 8'h04;

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr, StDummy, StRData, StQRData, StWData, StStatus, StIgnore
  } state_e;

  // Synchronizer bit order {sck, ncs, io3..io0}; ncs resets high so release is not a frame start.
  localparam logic [5:0] SyncRst = 6'b010000;

  logic [5:0] pads, sync_m_q, sync_s_q;
  logic [1:0] edge_p_q;
  logic       sck_s, ncs_s;
  logic [3:0] io_s;
  logic       sck_rise, sck_fall, ncs_rise, ncs_fall;
  logic       unused_io;

  assign pads     = {iSCK, inCS, iIO3_In, iIO2_In, iIO1_In, iIO0_In};
  assign sck_s    = sync_s_q[5];
  assign ncs_s    = sync_s_q[4];
  assign io_s     = sync_s_q[3:0];
  assign sck_rise = sck_s & ~edge_p_q[1];
  assign sck_fall = ~sck_s & edge_p_q[1];
  assign ncs_rise = ncs_s & ~edge_p_q[0];
  assign ncs_fall = ~ncs_s & edge_p_q[0];
  assign unused_io = ^io_s[3:1];

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      sync_m_q <= SyncRst;
      sync_s_q <= SyncRst;
      edge_p_q <= 2'b01;
    end else begin
      sync_m_q <= pads;
      sync_s_q <= sync_m_q;
      edge_p_q <= sync_s_q[5:4];
    end
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [SW-2:0]           shift_q, shift_d;
  logic [SW-1:0]           shift_in;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [7:0]              op_q, op_d;
  logic [7:0]              tx_q, tx_d;
  logic                    wel_q, wel_d;
  logic                    armed_q, armed_d;
  logic [3:0]              io_out_q, io_out_d;
  logic [3:0]              io_en_q, io_en_d;
  logic                    spi_we;
  logic                    byte_end;
  logic [7:0]              status_byte;
  logic [7:0]              rd_byte_q;
  logic [7:0]              bd_rdata_q;
  logic [7:0]              mem [DEPTH];

  assign shift_in    = {shift_q, io_s[0]};
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign byte_end    = (cnt_q == CNT_W'(7));
  assign status_byte = {6'b0, wel_q, 1'b0};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    tx_d     = tx_q;
    wel_d    = wel_q;
    armed_d  = armed_q;
    io_out_d = io_out_q;
    io_en_d  = io_en_q;
    spi_we   = 1'b0;

    if (ncs_rise) begin
      state_d = StIdle;
      cnt_d   = '0;
      io_en_d = 4'b0000;
      armed_d = 1'b0;
      // A write that started with WEL set consumes the latch when the frame closes.
      if (armed_q) wel_d = 1'b0;
    end else if (ncs_fall) begin
      state_d = StCmd;
      cnt_d   = '0;
      io_en_d = 4'b0000;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        StCmd: begin
          if (sck_rise) begin
            shift_d = shift_in[SW-2:0];
            cnt_d   = cnt_inc;
            if (byte_end) begin
              cnt_d = '0;
              op_d  = shift_in[7:0];
              case (shift_in[7:0])
                OpRead, OpQRead, OpWrite: state_d = StAddr;
                OpRdsr: state_d = StStatus;
                OpWren: begin
                  wel_d   = 1'b1;
                  state_d = StIgnore;
                end
                OpWrdi: begin
                  wel_d   = 1'b0;
                  state_d = StIgnore;
                end
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            shift_d = shift_in[SW-2:0];
            cnt_d   = cnt_inc;
            if (cnt_q == CNT_W'(23)) begin
              cnt_d = '0;
              ptr_d = shift_in[ADDR_WIDTH-1:0];
              if (op_q == OpRead) begin
                state_d = StRData;
              end else if (op_q == OpQRead) begin
                state_d = (DUMMY_CYCLES == 0) ? StQRData : StDummy;
              end else begin
                state_d = StWData;
                armed_d = wel_q;
              end
            end
          end
        end
        StDummy: begin
          if (sck_rise) begin
            cnt_d = cnt_inc;
            if (int'(cnt_q) == DUMMY_CYCLES - 1) begin
              cnt_d   = '0;
              state_d = StQRData;
            end
          end
        end
        StRData: begin
          if (sck_fall) begin
            io_en_d = 4'b0010;
            cnt_d   = byte_end ? '0 : cnt_inc;
            // rd_byte_q already holds mem[ptr]; advancing ptr here prefetches the next byte.
            if (cnt_q == '0) begin
              io_out_d[1] = rd_byte_q[7];
              tx_d        = {rd_byte_q[6:0], 1'b0};
              ptr_d       = ptr_q + ADDR_WIDTH'(1);
            end else begin
              io_out_d[1] = tx_q[7];
              tx_d        = {tx_q[6:0], 1'b0};
            end
          end
        end
        StQRData: begin
          if (sck_fall) begin
            io_en_d = 4'b1111;
            if (cnt_q == '0) begin
              io_out_d = rd_byte_q[7:4];
              tx_d     = rd_byte_q;
              ptr_d    = ptr_q + ADDR_WIDTH'(1);
              cnt_d    = CNT_W'(1);
            end else begin
              io_out_d = tx_q[3:0];
              cnt_d    = '0;
            end
          end
        end
        StWData: begin
          if (sck_rise) begin
            shift_d = shift_in[SW-2:0];
            cnt_d   = cnt_inc;
            if (byte_end) begin
              cnt_d  = '0;
              spi_we = wel_q;
              ptr_d  = ptr_q + ADDR_WIDTH'(1);
            end
          end
        end
        StStatus: begin
          if (sck_fall) begin
            io_en_d     = 4'b0010;
            io_out_d[1] = status_byte[3'd7 - cnt_q[2:0]];
            cnt_d       = byte_end ? '0 : cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      op_q       <= '0;
      tx_q       <= '0;
      wel_q      <= 1'b0;
      armed_q    <= 1'b0;
      io_out_q   <= '0;
      io_en_q    <= '0;
      bd_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      tx_q       <= tx_d;
      wel_q      <= wel_d;
      armed_q    <= armed_d;
      io_out_q   <= io_out_d;
      io_en_q    <= io_en_d;
      bd_rdata_q <= mem[iBd_Addr];
    end
  end

  // Array contents survive reset; an SPI byte write beats a same-cycle backdoor write.
  always_ff @(posedge iClk) begin
    if (spi_we) begin
      mem[ptr_q] <= shift_in[7:0];
    end else if (iBd_We) begin
      mem[iBd_Addr] <= iBd_WData;
    end
    rd_byte_q <= mem[ptr_q];
  end

  assign {oIO3_Out, oIO2_Out, oIO1_Out, oIO0_Out} = io_out_q;
  assign {oIO3_En, oIO2_En, oIO1_En, oIO0_En}     = io_en_q;
  assign oWEL      = wel_q;
  assign oBusy     = ~ncs_s;
  assign oBd_RData = bd_rdata_q;

endmodule

// File: tb/tb_raifes_qspi_mem_responder.sv
// Bench for raifes_qspi_mem_responder: directed vector table, corner-case sequences and
// randomized transactions against an array-based memory model.
module tb_raifes_qspi_mem_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int DUMMY = 8;
  localparam int HALF  = 5;

  logic          iClk = 1'b0;
  logic          iReset, iSCK, inCS;
  logic          iIO0_In, iIO1_In, iIO2_In, iIO3_In;
  logic          oIO0_Out, oIO1_Out, oIO2_Out, oIO3_Out;
  logic          oIO0_En, oIO1_En, oIO2_En, oIO3_En;
  logic          iBd_We;
  logic [AW-1:0] iBd_Addr;
  logic [7:0]    iBd_WData, oBd_RData;
  logic          oWEL, oBusy;

  always #5 iClk = ~iClk;

  raifes_qspi_mem_responder #(.ADDR_WIDTH(AW), .DUMMY_CYCLES(DUMMY)) dut (
    .iClk(iClk), .iReset(iReset), .iSCK(iSCK), .inCS(inCS),
    .iIO0_In(iIO0_In), .iIO1_In(iIO1_In), .iIO2_In(iIO2_In), .iIO3_In(iIO3_In),
    .oIO0_Out(oIO0_Out), .oIO1_Out(oIO1_Out), .oIO2_Out(oIO2_Out), .oIO3_Out(oIO3_Out),
    .oIO0_En(oIO0_En), .oIO1_En(oIO1_En), .oIO2_En(oIO2_En), .oIO3_En(oIO3_En),
    .iBd_We(iBd_We), .iBd_Addr(iBd_Addr), .iBd_WData(iBd_WData), .oBd_RData(oBd_RData),
    .oWEL(oWEL), .oBusy(oBusy)
  );

  logic [3:0] outs, ens;
  assign outs = {oIO3_Out, oIO2_Out, oIO1_Out, oIO0_Out};
  assign ens  = {oIO3_En, oIO2_En, oIO1_En, oIO0_En};

  int total = 0;
  int bad   = 0;

  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];
  int         pre_en_bad, data_en_bad;
  logic       busy_seen, busy_after;
  logic [3:0] en_after;
  logic [7:0] model_mem [DEPTH];
  logic       model_wel;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          n;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        wel;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic bit_cycle(input logic [3:0] din, output logic [3:0] dout,
                           output logic [3:0] den);
    {iIO3_In, iIO2_In, iIO1_In, iIO0_In} = din;
    tick(HALF);
    dout = outs;
    den  = ens;
    iSCK = 1'b1;
    tick(HALF);
    iSCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] o, e;
    logic [7:0] t;
    t = b;
    repeat (8) begin
      bit_cycle({3'b000, t[7]}, o, e);
      if (e != 4'b0000) pre_en_bad++;
      t = {t[6:0], 1'b0};
    end
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic [3:0] o, e;
    b = '0;
    repeat (8) begin
      bit_cycle(4'b0000, o, e);
      b = {b[6:0], o[1]};
      if (e !== 4'b0010) data_en_bad++;
    end
  endtask

  task automatic recv_qbyte(output logic [7:0] b);
    logic [3:0] o, e;
    bit_cycle(4'b0000, o, e);
    b[7:4] = o;
    if (e !== 4'b1111) data_en_bad++;
    bit_cycle(4'b0000, o, e);
    b[3:0] = o;
    if (e !== 4'b1111) data_en_bad++;
  endtask

  task automatic cs_low();
    inCS = 1'b0;
    tick(HALF);
    busy_seen = oBusy;
  endtask

  task automatic cs_high();
    tick(HALF);
    inCS = 1'b1;
    tick(3);
    en_after   = ens;
    busy_after = oBusy;
    tick(2 * HALF);
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
    iBd_Addr  = a;
    iBd_WData = d;
    iBd_We    = 1'b1;
    tick(1);
    iBd_We    = 1'b0;
  endtask

  task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] d);
    iBd_Addr = a;
    tick(1);
    d = oBd_RData;
  endtask

  task automatic run_xact(input logic [7:0] op, input logic [23:0] addr, input int n);
    logic [3:0] o, e;
    logic [7:0] b;
    pre_en_bad  = 0;
    data_en_bad = 0;
    cs_low();
    send_byte(op);
    if (op == 8'h03 || op == 8'h6B || op == 8'h02) begin
      send_byte(addr[23:16]);
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
    end
    if (op == 8'h6B) begin
      repeat (DUMMY) begin
        bit_cycle(4'b0000, o, e);
        if (e != 4'b0000) pre_en_bad++;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (op == 8'h03 || op == 8'h05) begin
        recv_byte(b);
        rbuf[i] = b;
      end else if (op == 8'h6B) begin
        recv_qbyte(b);
        rbuf[i] = b;
      end else begin
        send_byte(wbuf[i]);
      end
    end
    cs_high();
  endtask

  task automatic check_frame(input string tag, input logic exp_wel);
    check({tag, " pre_en"}, 32'(pre_en_bad), 32'd0);
    check({tag, " data_en"}, 32'(data_en_bad), 32'd0);
    check({tag, " en_after_cs"}, 32'(en_after), 32'd0);
    check({tag, " busy_in"}, 32'(busy_seen), 32'd1);
    check({tag, " busy_after"}, 32'(busy_after), 32'd0);
    check({tag, " wel"}, 32'(oWEL), 32'(exp_wel));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  o, e;
    logic [7:0]  d, col, t;
    logic [31:0] w;
    logic [7:0]  op;
    logic [23:0] addr;
    int          n, ai;
    logic [7:0]  known_ops [6];

    iReset = 1'b1; iSCK = 1'b0; inCS = 1'b1;
    {iIO3_In, iIO2_In, iIO1_In, iIO0_In} = 4'b0000;
    iBd_We = 1'b0; iBd_Addr = '0; iBd_WData = '0;
    tick(3);
    check("reset outs", 32'(outs), 32'd0);
    check("reset ens", 32'(ens), 32'd0);
    check("reset wel", 32'(oWEL), 32'd0);
    check("reset busy", 32'(oBusy), 32'd0);
    check("reset bd_rdata", 32'(oBd_RData), 32'd0);
    iReset = 1'b0;
    tick(3);

    bd_write(10'h008, 8'hBE); bd_write(10'h009, 8'hBA);
    bd_write(10'h00A, 8'hFE); bd_write(10'h00B, 8'hCA);
    bd_write(10'h010, 8'hA5);
    bd_write(10'h3FF, 8'h12); bd_write(10'h000, 8'h34);
    bd_write(10'h001, 8'h56); bd_write(10'h002, 8'h78);

    vecs[0]  = '{8'h03, 24'h000008, 4, 32'h0,        32'hBEBAFECA, 1'b0};
    vecs[1]  = '{8'h06, 24'h000000, 0, 32'h0,        32'h0,        1'b1};
    vecs[2]  = '{8'h02, 24'h000008, 4, 32'hCAFEBABE, 32'h0,        1'b0};
    vecs[3]  = '{8'h05, 24'h000000, 1, 32'h0,        32'h00000000, 1'b0};
    vecs[4]  = '{8'h03, 24'h000008, 4, 32'h0,        32'hCAFEBABE, 1'b0};
    vecs[5]  = '{8'h02, 24'h000010, 1, 32'h55000000, 32'h0,        1'b0};
    vecs[6]  = '{8'h05, 24'h000000, 1, 32'h0,        32'h00000000, 1'b0};
    vecs[7]  = '{8'h06, 24'h000000, 0, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{8'h05, 24'h000000, 2, 32'h0,        32'h02020000, 1'b1};
    vecs[9]  = '{8'h04, 24'h000000, 0, 32'h0,        32'h0,        1'b0};
    vecs[10] = '{8'h6B, 24'h0003FF, 4, 32'h0,        32'h12345678, 1'b0};
    vecs[11] = '{8'h03, 24'h0003FF, 2, 32'h0,        32'h12340000, 1'b0};
    vecs[12] = '{8'h03, 24'hABC008, 1, 32'h0,        32'hCA000000, 1'b0};

    for (int v = 0; v < 13; v++) begin
      w = vecs[v].wd;
      for (int i = 0; i < 4; i++) begin
        wbuf[i] = w[31:24];
        w = {w[23:0], 8'h00};
      end
      run_xact(vecs[v].op, vecs[v].addr, vecs[v].n);
      if (vecs[v].op == 8'h03 || vecs[v].op == 8'h6B || vecs[v].op == 8'h05) begin
        w = vecs[v].exp;
        for (int i = 0; i < vecs[v].n; i++) begin
          check($sformatf("vec%0d byte%0d", v, i), 32'(rbuf[i]), 32'(w[31:24]));
          w = {w[23:0], 8'h00};
        end
      end
      check_frame($sformatf("vec%0d", v), vecs[v].wel);
    end

    bd_read(10'h008, d); check("bd 0x008", 32'(d), 32'hCA);
    bd_read(10'h009, d); check("bd 0x009", 32'(d), 32'hFE);
    bd_read(10'h00A, d); check("bd 0x00A", 32'(d), 32'hBA);
    bd_read(10'h00B, d); check("bd 0x00B", 32'(d), 32'hBE);
    bd_read(10'h010, d); check("bd 0x010 unwritten", 32'(d), 32'hA5);

    // Write frame cut after 12 data bits: only the complete byte lands.
    bd_write(10'h020, 8'h66); bd_write(10'h021, 8'h77);
    run_xact(8'h06, 24'h0, 0);
    pre_en_bad = 0;
    cs_low();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h3C);
    t = 8'hF0;
    repeat (4) begin
      bit_cycle({3'b000, t[7]}, o, e);
      t = {t[6:0], 1'b0};
    end
    cs_high();
    check("partial wel", 32'(oWEL), 32'd0);
    bd_read(10'h020, d); check("partial 0x020", 32'(d), 32'h3C);
    bd_read(10'h021, d); check("partial 0x021", 32'(d), 32'h77);

    // Same framing with an unknown opcode: nothing driven or written, WEL untouched.
    run_xact(8'h06, 24'h0, 0);
    pre_en_bad = 0;
    cs_low();
    send_byte(8'h9F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'hC3);
    t = 8'h0F;
    repeat (4) begin
      bit_cycle({3'b000, t[7]}, o, e);
      if (e != 4'b0000) pre_en_bad++;
      t = {t[6:0], 1'b0};
    end
    cs_high();
    check("9F en", 32'(pre_en_bad), 32'd0);
    check("9F wel kept", 32'(oWEL), 32'd1);
    bd_read(10'h020, d); check("9F 0x020", 32'(d), 32'h3C);
    bd_read(10'h021, d); check("9F 0x021", 32'(d), 32'h77);

    // Backdoor write hitting the same iClk as the SPI byte write is dropped.
    bd_write(10'h030, 8'h11);
    col = 8'h5A;
    cs_low();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    t = col;
    repeat (7) begin
      bit_cycle({3'b000, t[7]}, o, e);
      t = {t[6:0], 1'b0};
    end
    {iIO3_In, iIO2_In, iIO1_In, iIO0_In} = {3'b000, t[7]};
    tick(HALF);
    iSCK = 1'b1;
    tick(2);
    iBd_We = 1'b1; iBd_Addr = 10'h030; iBd_WData = 8'hEE;
    tick(1);
    iBd_We = 1'b0;
    tick(HALF - 3);
    iSCK = 1'b0;
    cs_high();
    bd_read(10'h040, d); check("collision spi byte", 32'(d), 32'h5A);
    bd_read(10'h030, d); check("collision bd dropped", 32'(d), 32'h11);
    check("collision wel", 32'(oWEL), 32'd0);

    // Reset in the middle of a quad read.
    run_xact(8'h06, 24'h0, 0);
    data_en_bad = 0;
    cs_low();
    send_byte(8'h6B); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    repeat (DUMMY) bit_cycle(4'b0000, o, e);
    recv_qbyte(d);
    check("midreset qbyte", 32'(d), 32'hCA);
    check("midreset en before", 32'(ens), 32'hF);
    check("midreset wel before", 32'(oWEL), 32'd1);
    iReset = 1'b1;
    #1;
    check("midreset en", 32'(ens), 32'd0);
    check("midreset wel", 32'(oWEL), 32'd0);
    check("midreset bd_rdata", 32'(oBd_RData), 32'd0);
    inCS = 1'b1;
    tick(3);
    iReset = 1'b0;
    tick(4);
    run_xact(8'h03, 24'h000008, 2);
    check("post reset byte0", 32'(rbuf[0]), 32'hCA);
    check("post reset byte1", 32'(rbuf[1]), 32'hFE);
    check_frame("post reset", 1'b0);

    // Randomized transactions against the array model.
    known_ops = '{8'h03, 8'h6B, 8'h02, 8'h05, 8'h06, 8'h04};
    for (int a = 0; a < DEPTH; a++) begin
      model_mem[a] = 8'($urandom);
      bd_write(AW'(a), model_mem[a]);
    end
    model_wel = 1'b0;
    for (int tr = 0; tr < 30; tr++) begin
      ai = int'($urandom_range(0, 6));
      if (ai < 6) begin
        op = known_ops[ai];
      end else begin
        op = 8'($urandom);
        while (op == 8'h03 || op == 8'h6B || op == 8'h02 || op == 8'h05 ||
               op == 8'h06 || op == 8'h04) op = 8'($urandom);
      end
      addr = 24'($urandom);
      n    = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      run_xact(op, addr, n);
      for (int i = 0; i < n; i++) begin
        ai = (int'(addr[AW-1:0]) + i) % DEPTH;
        if (op == 8'h03 || op == 8'h6B)
          check($sformatf("rnd%0d op%0h byte%0d", tr, op, i), 32'(rbuf[i]),
                32'(model_mem[ai]));
        else if (op == 8'h05)
          check($sformatf("rnd%0d status%0d", tr, i), 32'(rbuf[i]),
                32'({6'b0, model_wel, 1'b0}));
        else if (op == 8'h02 && model_wel)
          model_mem[ai] = wbuf[i];
      end
      if (op == 8'h02) model_wel = 1'b0;
      if (op == 8'h06) model_wel = 1'b1;
      if (op == 8'h04) model_wel = 1'b0;
      check_frame($sformatf("rnd%0d", tr), model_wel);
    end

    for (int a = 0; a < DEPTH; a++) begin
      bd_read(AW'(a), d);
      check($sformatf("final mem[%0h]", a), 32'(d), 32'(model_mem[a]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
